// File: rtl/tri_feeder.sv
// tri_feeder: streams an object's triangles from vertex memory to the rasterizer.
module tri_feeder #(
  parameter int NUM_TRIS     = 12,
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start,
  input  logic              tri_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [26:0]       mem_data,
  output logic [8:0]        vert1 [2:0],
  output logic [8:0]        vert2 [2:0],
  output logic [8:0]        vert3 [2:0],
  output logic              valid_tri,
  output logic              new_frame,
  output logic              obj_done,
  output logic              busy
);
  localparam int IDX_W = NUM_TRIS < 2 ? 1 : $clog2(NUM_TRIS + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;
  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [1:0]              fk;
  logic [1:0]              ck;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic                    pending;
  logic                    start;
  logic                    last;
  logic [8:0]              word [2:0];
  assign start   = frame_start | pending;
  assign last    = idx == IDX_W'(NUM_TRIS - 1);
  assign word[2] = mem_data[26:18];
  assign word[1] = mem_data[17:9];
  assign word[0] = mem_data[8:0];
  // rd_pipe tracks in-flight reads; ck picks which vertex the returning word fills
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      idx       <= '0;
      fk        <= '0;
      ck        <= '0;
      rd_pipe   <= '0;
      pending   <= 1'b0;
      mem_addr  <= '0;
      valid_tri <= 1'b0;
      new_frame <= 1'b0;
      obj_done  <= 1'b0;
      busy      <= 1'b0;
      vert1     <= '{default: '0};
      vert2     <= '{default: '0};
      vert3     <= '{default: '0};
    end else begin
      new_frame <= 1'b0;
      rd_pipe   <= (rd_pipe << 1) | READ_LATENCY'(state == FETCH);
      if (rd_pipe[READ_LATENCY-1]) begin
        ck <= ck == 2'd2 ? 2'd0 : ck + 2'd1;
        if (ck == 2'd0) vert1 <= word;
        if (ck == 2'd1) vert2 <= word;
        if (ck == 2'd2) begin
          vert3     <= word;
          valid_tri <= 1'b1;
          state     <= PRESENT;
        end
      end
      if (frame_start && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (state == DONE && !obj_done) obj_done <= 1'b1;
          else begin
            obj_done <= 1'b0;
            if (start) begin
              idx       <= '0;
              fk        <= '0;
              mem_addr  <= '0;
              pending   <= 1'b0;
              new_frame <= 1'b1;
              busy      <= 1'b1;
              state     <= NUM_TRIS == 0 ? DONE : FETCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        FETCH: begin
          fk <= fk + 2'd1;
          if (fk == 2'd2) state <= WAIT;
          else mem_addr <= mem_addr + ADDR_W'(1);
        end
        PRESENT: begin
          if (tri_ready) begin
            valid_tri <= 1'b0;
            if (last) begin
              obj_done <= 1'b1;
              state    <= DONE;
            end else begin
              idx      <= idx + IDX_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
              fk       <= '0;
              state    <= FETCH;
            end
          end
        end
        WAIT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
